// File: rtl/cdb_writeback_pkg.sv
// Shared types and constants for the common-data-bus writeback unit.
package cdb_writeback_pkg;

   // Width of the per-bus arbiter grant address.
   localparam int ADDR_W = 8;

   // Entries are stored at the widest supported size; narrower
   // configurations zero-extend on the way in and truncate on the way out.
   localparam int WB_MAX_XLEN  = 64;
   localparam int WB_MAX_TAG_W = 16;

   typedef struct packed {
      logic [WB_MAX_XLEN-1:0]  result;
      logic [WB_MAX_XLEN-1:0]  jump;
      logic [WB_MAX_TAG_W-1:0] tag;
   } wb_entry_t;

   // Bundle the three result fields into one stored entry.
   function automatic wb_entry_t make_entry(input logic [WB_MAX_XLEN-1:0]  result,
                                            input logic [WB_MAX_XLEN-1:0]  jump,
                                            input logic [WB_MAX_TAG_W-1:0] tag);
      wb_entry_t e;
      e.result = result;
      e.jump   = jump;
      e.tag    = tag;
      return e;
   endfunction

endpackage

// File: rtl/cdb_writeback_fifo.sv
// Multi-pop ring buffer holding completed results; the first BUS_COUNT
// entries from the head are visible at once so several buses can drain
// it in a single cycle.
module wb_fifo
   import cdb_writeback_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int BUS_COUNT = 2,
   localparam int PTR_W    = $clog2(DEPTH),
   localparam int CNT_W    = $clog2(DEPTH) + 1,
   localparam int POP_W    = $clog2(BUS_COUNT + 1)
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            flush,
   input  logic                            push,
   input  wb_entry_t                       push_data,
   input  logic [POP_W-1:0]                pop_cnt,
   output logic [CNT_W-1:0]                count,
   output logic                            full,
   output wb_entry_t [BUS_COUNT-1:0]       peek
);

   wb_entry_t          mem_q [DEPTH];
   logic [PTR_W-1:0]   head_q, head_d;
   logic [PTR_W-1:0]   tail_q, tail_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               full_q, full_d;

   // Next pointer/count state; flush empties the buffer but never blocks the drive.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         // Pointers are power-of-two wide, so plain addition wraps modulo DEPTH.
         head_d  = head_q + PTR_W'(pop_cnt);
         tail_d  = tail_q + PTR_W'(push);
         count_d = count_q + CNT_W'(push) - CNT_W'(pop_cnt);
      end
      full_d = (count_d == CNT_W'(DEPTH));
   end

   // Control state registers; reset discards every buffered entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         full_q  <= full_d;
      end
   end

   // Entry storage; contents are only meaningful while counted, so no reset.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem_q[tail_q] <= push_data;
      end
   end

   // Expose the oldest BUS_COUNT slots for same-cycle multi-bus drive.
   always_comb begin
      for (int i = 0; i < BUS_COUNT; i++) begin
         peek[i] = mem_q[head_q + PTR_W'(i)];
      end
   end

   assign count = count_q;
   assign full  = full_q;

endmodule

// File: rtl/cdb_writeback.sv
// Writeback stage: buffers execution results and broadcasts them on the
// common data buses this unit is granted, oldest result first.
module cdb_writeback
   import cdb_writeback_pkg::*;
#(
   parameter int                XLEN      = 32,
   parameter int                DEPTH     = 4,
   parameter int                BUS_COUNT = 2,
   parameter int                TAG_W     = 6,
   parameter logic [ADDR_W-1:0] ADDRESS   = 8'h00
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        flush,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [XLEN-1:0]             in_result,
   input  logic [XLEN-1:0]             in_jump,
   input  logic [TAG_W-1:0]            in_tag,
   input  logic [BUS_COUNT*ADDR_W-1:0] bus_select,
   output logic [BUS_COUNT-1:0]        bus_req,
   output logic [BUS_COUNT-1:0]        bus_valid,
   output logic [BUS_COUNT*XLEN-1:0]   bus_result,
   output logic [BUS_COUNT*XLEN-1:0]   bus_jump,
   output logic [BUS_COUNT*TAG_W-1:0]  bus_tag,
   output logic                        full
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int POP_W = $clog2(BUS_COUNT + 1);

   logic [CNT_W-1:0]            count;
   logic                        fifo_full;
   logic                        push;
   logic [POP_W-1:0]            pop_cnt;
   logic [BUS_COUNT-1:0]        grant;
   wb_entry_t                   push_data;
   wb_entry_t [BUS_COUNT-1:0]   peek;
   logic                        unused_peek_bits;

   // Acceptance looks only at the registered count; a same-cycle pop does not free a slot.
   assign in_ready = (count < CNT_W'(DEPTH));
   assign push     = in_valid && in_ready;
   assign full     = fifo_full;

   // Widen the incoming result into the storage entry format.
   always_comb begin
      push_data = make_entry(WB_MAX_XLEN'(in_result),
                             WB_MAX_XLEN'(in_jump),
                             WB_MAX_TAG_W'(in_tag));
   end

   // Request one bus per buffered entry; a bus is ours when its grant address matches.
   always_comb begin
      bus_req = '0;
      grant   = '0;
      for (int b = 0; b < BUS_COUNT; b++) begin
         bus_req[b] = (count > CNT_W'(b));
         grant[b]   = bus_req[b] && (bus_select[b*ADDR_W +: ADDR_W] == ADDRESS);
      end
   end

   // Granted buses take consecutive entries from the head in ascending bus order.
   always_comb begin
      logic [POP_W-1:0] rank;
      rank       = '0;
      bus_valid  = '0;
      bus_result = '0;
      bus_jump   = '0;
      bus_tag    = '0;
      for (int b = 0; b < BUS_COUNT; b++) begin
         if (grant[b]) begin
            bus_valid[b] = 1'b1;
            for (int i = 0; i < BUS_COUNT; i++) begin
               if (rank == POP_W'(i)) begin
                  bus_result[b*XLEN +: XLEN]  = peek[i].result[XLEN-1:0];
                  bus_jump[b*XLEN +: XLEN]    = peek[i].jump[XLEN-1:0];
                  bus_tag[b*TAG_W +: TAG_W]   = peek[i].tag[TAG_W-1:0];
               end
            end
            rank = rank + POP_W'(1);
         end
      end
      pop_cnt = rank;
   end

   // Storage is sized for the widest configuration; fold the spare bits away.
   always_comb begin
      unused_peek_bits = ^peek;
   end

   wb_fifo #(
      .DEPTH     (DEPTH),
      .BUS_COUNT (BUS_COUNT)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .push      (push),
      .push_data (push_data),
      .pop_cnt   (pop_cnt),
      .count     (count),
      .full      (fifo_full),
      .peek      (peek)
   );

endmodule

// File: tb/tb_cdb_writeback.sv
// Bench for cdb_writeback: directed scenarios with literal expectations
// plus randomized traffic checked against a queue-based model.
module tb_cdb_writeback;

   localparam int XLEN  = 32;
   localparam int DEPTH = 4;
   localparam int NB    = 2;
   localparam int TAG_W = 6;
   localparam logic [7:0] ADDR  = 8'h5A;
   localparam logic [7:0] OTHER = 8'h00;

   logic                clk = 1'b0;
   logic                reset, flush, in_valid, in_ready, full;
   logic [XLEN-1:0]     in_result, in_jump;
   logic [TAG_W-1:0]    in_tag;
   logic [NB*8-1:0]     bus_select;
   logic [NB-1:0]       bus_req, bus_valid;
   logic [NB*XLEN-1:0]  bus_result, bus_jump;
   logic [NB*TAG_W-1:0] bus_tag;

   typedef struct {
      logic [XLEN-1:0]  r;
      logic [XLEN-1:0]  j;
      logic [TAG_W-1:0] t;
   } ent_t;

   ent_t model_q[$];
   bit   model_ok = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   cdb_writeback #(
      .XLEN(XLEN), .DEPTH(DEPTH), .BUS_COUNT(NB), .TAG_W(TAG_W), .ADDRESS(ADDR)
   ) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_result(in_result), .in_jump(in_jump), .in_tag(in_tag),
      .bus_select(bus_select), .bus_req(bus_req), .bus_valid(bus_valid),
      .bus_result(bus_result), .bus_jump(bus_jump), .bus_tag(bus_tag),
      .full(full)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Model: outputs derived from queue occupancy and the current grants.
   int                  n_m, rank_m;
   logic [NB-1:0]       er_m, ev_m;
   logic [NB*XLEN-1:0]  eres_m, ejmp_m;
   logic [NB*TAG_W-1:0] etag_m;

   always @(negedge clk) begin
      n_m = model_q.size();
      rank_m = 0;
      er_m = '0; ev_m = '0; eres_m = '0; ejmp_m = '0; etag_m = '0;
      for (int b = 0; b < NB; b++) begin
         er_m[b] = (n_m > b);
         if (er_m[b] && bus_select[b*8 +: 8] == ADDR) begin
            ev_m[b] = 1'b1;
            eres_m[b*XLEN +: XLEN]  = model_q[rank_m].r;
            ejmp_m[b*XLEN +: XLEN]  = model_q[rank_m].j;
            etag_m[b*TAG_W +: TAG_W] = model_q[rank_m].t;
            rank_m++;
         end
      end
      if (model_ok) begin
         check("in_ready",   in_ready,   (n_m < DEPTH));
         check("full",       full,       (n_m == DEPTH));
         check("bus_req",    bus_req,    er_m);
         check("bus_valid",  bus_valid,  ev_m);
         check("bus_result", bus_result, eres_m);
         check("bus_jump",   bus_jump,   ejmp_m);
         check("bus_tag",    bus_tag,    etag_m);
      end
      if (reset) begin
         model_q.delete();
         model_ok = 1'b1;
      end else if (flush) begin
         model_q.delete();
      end else begin
         for (int k = 0; k < rank_m; k++) void'(model_q.pop_front());
         if (in_valid && n_m < DEPTH) model_q.push_back('{in_result, in_jump, in_tag});
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic idle();
      in_valid   = 1'b0;
      flush      = 1'b0;
      bus_select = {OTHER, OTHER};
   endtask

   task automatic offer(input logic [31:0] r);
      in_valid  = 1'b1;
      in_result = r;
      in_jump   = r ^ 32'hFFFF_0000;
      in_tag    = r[5:0];
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      idle();
      in_result = '0; in_jump = '0; in_tag = '0;
      cyc(); cyc();
      reset = 1'b0;
      settle();
      check("rst_in_ready",  in_ready,  1'b1);
      check("rst_full",      full,      1'b0);
      check("rst_bus_req",   bus_req,   2'b00);
      check("rst_bus_valid", bus_valid, 2'b00);

      // Single push, no grant: one request, nothing driven.
      cyc(); offer(32'h11); in_tag = 6'd3;
      cyc(); idle(); settle();
      check("one_req",   bus_req,   2'b01);
      check("one_valid", bus_valid, 2'b00);
      cyc(); bus_select = {OTHER, ADDR}; settle();
      check("one_result", bus_result, {32'h0, 32'h11});
      check("one_tag",    bus_tag,    {6'd0, 6'd3});

      // Two entries drained by both buses in one cycle.
      cyc(); idle(); offer(32'hA);
      cyc(); offer(32'hB);
      cyc(); idle(); bus_select = {ADDR, ADDR}; settle();
      check("dual_result", bus_result, {32'hB, 32'hA});
      check("dual_valid",  bus_valid,  2'b11);
      cyc(); idle(); settle();
      check("dual_empty", bus_req, 2'b00);

      // Fill to capacity, refuse an extra offer, then free one slot.
      for (int i = 0; i < DEPTH; i++) begin
         cyc(); offer(32'h20 + i);
      end
      cyc(); offer(32'h99); settle();
      check("fill_full",  full,     1'b1);
      check("fill_ready", in_ready, 1'b0);
      check("fill_req",   bus_req,  2'b11);
      cyc(); in_valid = 1'b0; bus_select = {OTHER, ADDR}; settle();
      check("fill_head", bus_result, {32'h0, 32'h20});
      cyc(); idle(); settle();
      check("fill_nfull", full,     1'b0);
      check("fill_ready2", in_ready, 1'b1);
      cyc(); bus_select = {ADDR, ADDR}; settle();
      check("fill_pair", bus_result, {32'h22, 32'h21});
      cyc(); bus_select = {ADDR, ADDR}; settle();
      check("fill_last",  bus_result, {32'h0, 32'h23});
      check("fill_lastv", bus_valid,  2'b01);
      cyc(); idle(); settle();
      check("fill_drained", bus_req, 2'b00);

      // Only bus 1 granted: it carries the head, bus 0 stays quiet.
      cyc(); offer(32'h31);
      cyc(); offer(32'h32);
      cyc(); idle(); bus_select = {ADDR, OTHER}; settle();
      check("b1_valid",  bus_valid,  2'b10);
      check("b1_result", bus_result, {32'h31, 32'h0});
      cyc(); bus_select = {ADDR, ADDR}; settle();
      check("b1_next", bus_result, {32'h0, 32'h32});
      cyc(); idle();

      // Flush with a simultaneous offer: buffer empties, offer dropped.
      offer(32'h51);
      cyc(); offer(32'h52);
      cyc(); offer(32'h53);
      cyc(); offer(32'h77); flush = 1'b1;
      cyc(); idle(); settle();
      check("flush_req",   bus_req,  2'b00);
      check("flush_ready", in_ready, 1'b1);
      cyc(); offer(32'h41);
      cyc(); idle(); bus_select = {OTHER, ADDR}; settle();
      check("flush_after", bus_result, {32'h0, 32'h41});
      check("flush_req1",  bus_req,    2'b01);

      // Steady push/pop for several laps of the ring.
      for (int i = 0; i < 3*DEPTH; i++) begin
         cyc(); offer(32'h100 + i); bus_select = {OTHER, ADDR}; settle();
         if (i > 0) check("wrap_order", bus_result[31:0], 32'h100 + i - 1);
      end
      cyc(); idle(); bus_select = {OTHER, ADDR};
      cyc(); idle();

      // Randomized traffic against the model.
      for (int c = 0; c < 800; c++) begin
         cyc();
         reset     = ($urandom_range(0, 63) == 0);
         flush     = ($urandom_range(0, 31) == 0);
         in_valid  = ($urandom_range(0, 9) < 7);
         in_result = $urandom;
         in_jump   = $urandom;
         in_tag    = TAG_W'($urandom);
         for (int b = 0; b < NB; b++) begin
            bus_select[b*8 +: 8] = ($urandom_range(0, 9) < 5) ? ADDR : 8'($urandom);
         end
      end
      cyc(); reset = 1'b0; idle();
      cyc(); cyc();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
